// File: rtl/traffic_pkg.sv
// Shared defaults for the pedestrian request path feeding the traffic-light controller.
package traffic_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned DEBOUNCE_DEF    = 4;
  localparam int unsigned LOCKOUT_DEF     = 16;

  // Counters must hold the larger of the debounce and lockout load values.
  localparam int unsigned CNT_MAX_DEF = (DEBOUNCE_DEF > LOCKOUT_DEF) ? DEBOUNCE_DEF : LOCKOUT_DEF;
  localparam int unsigned CNT_W_MIN   = $clog2(CNT_MAX_DEF + 1);
  localparam int unsigned CNT_W_DEF   = (CNT_W_MIN > 8) ? CNT_W_MIN : 8;

endpackage

// File: rtl/ped_debounce_channel.sv
// One pedestrian button: synchroniser, debounce, rising-edge request pulse and lockout window.
module ped_debounce_channel
  import traffic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int unsigned LOCKOUT_CYCLES  = LOCKOUT_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic ped,
  output logic btn_stable,
  output logic lockout
);

  localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LockLoad = CNT_W'(LOCKOUT_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic                   stable_q, stable_d;
  logic                   ped_q, ped_d;
  logic                   lockout_q, lockout_d;
  logic                   s;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], btn_raw};
    s          = sync_q[SYNC_STAGES-1];
    stable_d   = stable_q;
    db_cnt_d   = '0;
    ped_d      = 1'b0;
    lock_cnt_d = lock_cnt_q;

    if (s != stable_q) begin
      if (db_cnt_q == DbLast) begin
        stable_d = s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    // A rise that lands while the window is open is dropped, not queued.
    ped_d = stable_d & ~stable_q & (lock_cnt_q == '0);

    if (ped_d) begin
      lock_cnt_d = LockLoad;
    end else if (lock_cnt_q != '0) begin
      lock_cnt_d = lock_cnt_q - 1'b1;
    end

    lockout_d = (lock_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q     <= '0;
      db_cnt_q   <= '0;
      lock_cnt_q <= '0;
      stable_q   <= 1'b0;
      ped_q      <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      db_cnt_q   <= db_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      stable_q   <= stable_d;
      ped_q      <= ped_d;
      lockout_q  <= lockout_d;
    end
  end

  assign ped        = ped_q;
  assign btn_stable = stable_q;
  assign lockout    = lockout_q;

endmodule

// File: rtl/ped_request_conditioner.sv
// Conditions the NS and EW pedestrian buttons into single-cycle requests for the controller.
module ped_request_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int unsigned LOCKOUT_CYCLES  = LOCKOUT_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_NS_raw,
  input  logic btn_EW_raw,
  output logic ped_NS,
  output logic ped_EW,
  output logic btn_NS_stable,
  output logic btn_EW_stable,
  output logic lockout_NS,
  output logic lockout_EW
);

  ped_debounce_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .LOCKOUT_CYCLES  (LOCKOUT_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ns (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_NS_raw),
    .ped        (ped_NS),
    .btn_stable (btn_NS_stable),
    .lockout    (lockout_NS)
  );

  ped_debounce_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .LOCKOUT_CYCLES  (LOCKOUT_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ew (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_EW_raw),
    .ped        (ped_EW),
    .btn_stable (btn_EW_stable),
    .lockout    (lockout_EW)
  );

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Randomised and directed bench for ped_request_conditioner with an edge-indexed reference model.
module tb_ped_request_conditioner;

  localparam int S    = 2;
  localparam int D    = 4;
  localparam int L    = 16;
  localparam int MAXE = 16384;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_NS_raw = 1'b0;
  logic btn_EW_raw = 1'b0;
  logic ped_NS, ped_EW, btn_NS_stable, btn_EW_stable, lockout_NS, lockout_EW;

  ped_request_conditioner #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D),
    .LOCKOUT_CYCLES  (L),
    .CNT_W           (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_NS_raw    (btn_NS_raw),
    .btn_EW_raw    (btn_EW_raw),
    .ped_NS        (ped_NS),
    .ped_EW        (ped_EW),
    .btn_NS_stable (btn_NS_stable),
    .btn_EW_stable (btn_EW_stable),
    .lockout_NS    (lockout_NS),
    .lockout_EW    (lockout_EW)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    bit       rst_edge;
    bit [1:0] ped;
    bit [1:0] stab;
    bit [1:0] lock;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: every quantity is expressed in terms of absolute edge numbers.
  bit raw_log [2][MAXE];
  bit s_log   [2][MAXE];
  int t = 0;
  int last_rst = 0;
  int last_flip [2];
  int last_pulse[2];
  bit has_pulse [2];
  bit stab      [2];

  always @(posedge clk) begin
    exp_t e;
    bit [1:0] raw;
    bit s, flip, pulse;
    raw = {btn_EW_raw, btn_NS_raw};
    t++;
    e = '0;
    if (!rst) begin
      last_rst = t;
      e.rst_edge = 1'b1;
      for (int ch = 0; ch < 2; ch++) begin
        stab[ch] = 1'b0;
        has_pulse[ch] = 1'b0;
        last_flip[ch] = t;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        raw_log[ch][t] = raw[ch];
        s = (t - S > last_rst) ? raw_log[ch][t-S] : 1'b0;
        s_log[ch][t] = s;
        // Flip when the last D samples since the previous flip all disagree with stable.
        flip = 1'b1;
        for (int k = 0; k < D; k++) begin
          if (t - k <= last_flip[ch]) flip = 1'b0;
          else if (s_log[ch][t-k] == stab[ch]) flip = 1'b0;
        end
        pulse = 1'b0;
        if (flip) begin
          if (!stab[ch] && (!has_pulse[ch] || (t - last_pulse[ch] >= L + 1))) pulse = 1'b1;
          stab[ch] = ~stab[ch];
          last_flip[ch] = t;
        end
        if (pulse) begin
          has_pulse[ch] = 1'b1;
          last_pulse[ch] = t;
        end
        e.ped[ch]  = pulse;
        e.stab[ch] = stab[ch];
        e.lock[ch] = has_pulse[ch] && (t - last_pulse[ch] < L);
      end
    end
    exp_q.push_back(e);
  end

  // Monitor: pops one expectation per edge, also checks pulse spacing per channel.
  int mon_cyc = 0;
  int dut_pulses [2] = '{0, 0};
  int dut_last   [2];
  bit dut_has    [2] = '{0, 0};

  always @(posedge clk) begin
    exp_t e;
    bit [5:0] act, want;
    bit [1:0] p;
    #1;
    mon_cyc++;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty: got no expectation at cycle %0d, required one", mon_cyc);
    end else begin
      e = exp_q.pop_front();
      act  = {ped_EW, ped_NS, btn_EW_stable, btn_NS_stable, lockout_EW, lockout_NS};
      want = {e.ped, e.stab, e.lock};
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL outputs@%0d: got ped/stab/lock=%b required %b", mon_cyc, act, want);
      end
      p = {ped_EW, ped_NS};
      for (int ch = 0; ch < 2; ch++) begin
        if (e.rst_edge) dut_has[ch] = 1'b0;
        if (p[ch] === 1'b1) begin
          dut_pulses[ch]++;
          if (dut_has[ch]) begin
            checks++;
            if (mon_cyc - dut_last[ch] < L + 1) begin
              errors++;
              $display("FAIL spacing_ch%0d: got gap %0d required >= %0d", ch,
                       mon_cyc - dut_last[ch], L + 1);
            end
          end
          dut_has[ch] = 1'b1;
          dut_last[ch] = mon_cyc;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input logic ns, input logic ew);
    btn_NS_raw = ns;
    btn_EW_raw = ew;
  endtask

  task automatic expect_pulses(input string name, input int ns0, input int ew0,
                               input int ns_exp, input int ew_exp);
    checks += 2;
    if (dut_pulses[0] - ns0 != ns_exp) begin
      errors++;
      $display("FAIL %s_ns_count: got %0d required %0d", name, dut_pulses[0] - ns0, ns_exp);
    end
    if (dut_pulses[1] - ew0 != ew_exp) begin
      errors++;
      $display("FAIL %s_ew_count: got %0d required %0d", name, dut_pulses[1] - ew0, ew_exp);
    end
  endtask

  initial begin
    int ns0, ew0;
    int bounce [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    int rem [2];
    bit lvl [2];

    // Reset with both buttons held: one coincident pulse after release.
    set_btn(1'b1, 1'b1);
    rst = 1'b0;
    cyc(3);
    ns0 = dut_pulses[0]; ew0 = dut_pulses[1];
    rst = 1'b1;
    cyc(20);
    expect_pulses("reset_hold", ns0, ew0, 1, 1);
    set_btn(1'b0, 1'b0);
    cyc(30);

    // Clean NS press held 20 cycles.
    ns0 = dut_pulses[0]; ew0 = dut_pulses[1];
    set_btn(1'b1, 1'b0);
    cyc(20);
    set_btn(1'b0, 1'b0);
    cyc(30);
    expect_pulses("clean_press", ns0, ew0, 1, 0);

    // Bouncy EW press.
    ns0 = dut_pulses[0]; ew0 = dut_pulses[1];
    foreach (bounce[i]) begin
      btn_EW_raw = bounce[i][0];
      cyc(1);
    end
    cyc(5);
    set_btn(1'b0, 1'b0);
    cyc(30);
    expect_pulses("bounce", ns0, ew0, 0, 1);

    // Lockout: second press inside the window is dropped, third after it is accepted.
    ns0 = dut_pulses[0]; ew0 = dut_pulses[1];
    set_btn(1'b1, 1'b0); cyc(4);
    set_btn(1'b0, 1'b0); cyc(4);
    set_btn(1'b1, 1'b0); cyc(6);
    set_btn(1'b0, 1'b0); cyc(6);
    set_btn(1'b1, 1'b0); cyc(8);
    set_btn(1'b0, 1'b0); cyc(30);
    expect_pulses("lockout", ns0, ew0, 2, 0);

    // Simultaneous press on both channels.
    ns0 = dut_pulses[0]; ew0 = dut_pulses[1];
    set_btn(1'b1, 1'b1); cyc(8);
    set_btn(1'b0, 1'b0); cyc(30);
    expect_pulses("simultaneous", ns0, ew0, 1, 1);

    // Reset mid-debounce aborts the press.
    ns0 = dut_pulses[0]; ew0 = dut_pulses[1];
    set_btn(1'b1, 1'b0); cyc(4);
    rst = 1'b0;
    set_btn(1'b0, 1'b0); cyc(2);
    rst = 1'b1;
    cyc(20);
    expect_pulses("mid_reset", ns0, ew0, 0, 0);

    // Random soak with independent per-channel level runs and rare resets.
    rem = '{0, 0};
    lvl = '{0, 0};
    for (int i = 0; i < 2500; i++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (rem[ch] == 0) begin
          lvl[ch] = ~lvl[ch];
          rem[ch] = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14));
        end
        rem[ch]--;
      end
      set_btn(lvl[0], lvl[1]);
      rst = ($urandom_range(0, 400) == 0) ? 1'b0 : 1'b1;
      cyc(1);
    end
    rst = 1'b1;
    set_btn(1'b0, 1'b0);
    cyc(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
